// File: rtl/cache_assoc_unit_pkg.sv
// Shared state encodings and width helpers for the set-associative cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

  // Encodings are visible on the 3-bit debug status port, so values are fixed.
  typedef enum logic [2:0] {
    STAT_NORMAL    = 3'd0,
    STAT_WRITEBACK = 3'd1,
    STAT_REFILL    = 3'd2,
    STAT_RESUME    = 3'd3
  } cache_state_t;

  // Way-select width; a direct-mapped build still carries a 1-bit way field.
  function automatic int way_idx_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

endpackage

// File: rtl/cache_assoc_unit_if.sv
// CPU-side and RAM-side buses of the cache grouped into one bundle.
// Latency: n/a (wiring only).
// Backpressure: CPU side stalled by mem_stall; RAM side paced by ram_ready.
interface cache_assoc_unit_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  import cache_pkg::*;

  logic                    req;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] byte_w_en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    mem_stall;
  logic [DATA_WIDTH-1:0]   rdata;

  logic                    ram_en;
  logic                    ram_write;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    ram_ready;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // Cache view: consumes CPU requests and RAM responses.
  modport slave (
    input  req, we, byte_w_en, addr, wdata, ram_ready, ram_rdata,
    output mem_stall, rdata, ram_en, ram_write, ram_addr, ram_wdata
  );

  // Environment view: the CPU memory stage plus the RAM controller.
  modport master (
    output req, we, byte_w_en, addr, wdata, ram_ready, ram_rdata,
    input  mem_stall, rdata, ram_en, ram_write, ram_addr, ram_wdata
  );
endinterface

// File: rtl/cache_assoc_unit_way.sv
// One cache way: tag/valid/dirty per set plus a word-addressed data array.
// Latency: combinational read; writes land on the next rising edge.
// Backpressure: none; the controller sequences every write.
module cache_way
  import cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 7,
  parameter int TAG_WIDTH    = 20,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  i_rd_index,
  input  logic [OFFSET_WIDTH-1:0] i_rd_offset,
  output logic                    o_valid,
  output logic                    o_dirty,
  output logic [TAG_WIDTH-1:0]    o_tag,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  input  logic                    i_cpu_we,
  input  logic [INDEX_WIDTH-1:0]  i_cpu_index,
  input  logic [OFFSET_WIDTH-1:0] i_cpu_offset,
  input  logic [DATA_WIDTH/8-1:0] i_cpu_be,
  input  logic [DATA_WIDTH-1:0]   i_cpu_wdata,
  input  logic                    i_fill_we,
  input  logic [INDEX_WIDTH-1:0]  i_fill_index,
  input  logic [OFFSET_WIDTH-1:0] i_fill_offset,
  input  logic [DATA_WIDTH-1:0]   i_fill_wdata,
  input  logic                    i_fill_done,
  input  logic [TAG_WIDTH-1:0]    i_fill_tag
);
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int BLOCK = 1 << OFFSET_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_data [SETS*BLOCK];
  logic [TAG_WIDTH-1:0]  r_tag  [SETS];
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;

  // Lookup port: set/word chosen by the controller (CPU address or writeback beat).
  always_comb begin
    o_valid = r_valid[i_rd_index];
    o_dirty = r_dirty[i_rd_index];
    o_tag   = r_tag[i_rd_index];
    o_rdata = r_data[{i_rd_index, i_rd_offset}];
  end

  // Data array is never reset; refill writes whole words, stores merge byte lanes.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_data[{i_fill_index, i_fill_offset}] <= i_fill_wdata;
    end else if (i_cpu_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_cpu_be[b]) begin
          r_data[{i_cpu_index, i_cpu_offset}][b*8 +: 8] <= i_cpu_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Tag is written only when the last refill beat lands.
  always_ff @(posedge clk) begin
    if (i_fill_done) begin
      r_tag[i_fill_index] <= i_fill_tag;
    end
  end

  // Line becomes valid/clean only on fill completion, so an aborted fill stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_done) begin
      r_valid[i_fill_index] <= 1'b1;
      r_dirty[i_fill_index] <= 1'b0;
    end else if (i_cpu_we) begin
      r_dirty[i_cpu_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_assoc_unit.sv
// N-way write-back/write-allocate data cache with word-serial RAM refill/writeback.
// Latency: hits answer combinationally; a miss stalls for writeback+refill beats plus one resume cycle.
// Backpressure: mem_stall holds the CPU; each RAM beat waits for ram_ready. Optional CACHE_PERF_CNT_EN adds event counters.
module cache_assoc_unit
  import cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 7,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int WAYS         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_assoc_unit_if.slave       bus,
  output logic [2:0]              status,
  output logic [OFFSET_WIDTH-1:0] counter
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             wb_cnt
`endif
);
  localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
  localparam int WIDX      = way_idx_width(WAYS);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

  cache_state_t            r_state, w_state_nxt;
  logic [OFFSET_WIDTH-1:0] r_counter, w_counter_nxt;
  logic [TAG_WIDTH-1:0]    r_req_tag;
  logic [INDEX_WIDTH-1:0]  r_req_index;
  logic [TAG_WIDTH-1:0]    r_wb_tag;
  logic [WIDX-1:0]         r_way;

  logic [TAG_WIDTH-1:0]    w_tag;
  logic [INDEX_WIDTH-1:0]  w_index;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic [INDEX_WIDTH-1:0]  w_rd_index;
  logic [OFFSET_WIDTH-1:0] w_rd_offset;

  logic [WAYS-1:0]         w_way_valid, w_way_dirty, w_hit_vec, w_cpu_we, w_fill_we;
  logic [TAG_WIDTH-1:0]    w_way_tag   [WAYS];
  logic [DATA_WIDTH-1:0]   w_way_rdata [WAYS];

  logic                    w_hit;
  logic [DATA_WIDTH-1:0]   w_hit_word;
  logic [WIDX-1:0]         w_victim, w_rr_cur;
  logic                    w_victim_dirty;
  logic                    w_cpu_write;
  logic                    w_miss_start, w_fill, w_fill_done;
  logic                    w_ram_en, w_ram_write;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;

  assign w_tag    = bus.addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_index  = bus.addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_offset = bus.addr[OFFSET_WIDTH-1:0];

  // The single read port per way follows the writeback beat, otherwise the CPU address.
  assign w_rd_index  = (r_state == STAT_WRITEBACK) ? r_req_index : w_index;
  assign w_rd_offset = (r_state == STAT_WRITEBACK) ? r_counter   : w_offset;

  assign w_cpu_write = (r_state == STAT_NORMAL) && bus.req && bus.we && w_hit;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_cpu_we[g]  = w_cpu_write && w_hit_vec[g];
    assign w_fill_we[g] = w_fill && (r_way == WIDX'(g));

    cache_way #(
      .OFFSET_WIDTH(OFFSET_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .i_rd_index   (w_rd_index),
      .i_rd_offset  (w_rd_offset),
      .o_valid      (w_way_valid[g]),
      .o_dirty      (w_way_dirty[g]),
      .o_tag        (w_way_tag[g]),
      .o_rdata      (w_way_rdata[g]),
      .i_cpu_we     (w_cpu_we[g]),
      .i_cpu_index  (w_index),
      .i_cpu_offset (w_offset),
      .i_cpu_be     (bus.byte_w_en),
      .i_cpu_wdata  (bus.wdata),
      .i_fill_we    (w_fill_we[g]),
      .i_fill_index (r_req_index),
      .i_fill_offset(r_counter),
      .i_fill_wdata (bus.ram_rdata),
      .i_fill_done  (w_fill_done && (r_way == WIDX'(g))),
      .i_fill_tag   (r_req_tag)
    );
  end

  // Tag compare across ways; invalid ways never match and refill-on-miss keeps matches unique.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_word = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_hit_vec[i] = w_way_valid[i] && (w_way_tag[i] == w_tag);
      if (w_hit_vec[i]) begin
        w_hit_word = w_way_rdata[i];
      end
    end
  end
  assign w_hit = |w_hit_vec;

  // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_victim = w_rr_cur;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!w_way_valid[i]) begin
        w_victim = WIDX'(i);
      end
    end
  end
  assign w_victim_dirty = w_way_valid[w_victim] && w_way_dirty[w_victim];

  if (WAYS > 1) begin : g_rr
    logic [WIDX-1:0] r_rr_ptr [SETS];

    // Per-set round-robin pointer, advanced each time a fill completes in that set.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++) begin
          r_rr_ptr[s] <= '0;
        end
      end else if (w_fill_done) begin
        r_rr_ptr[r_req_index] <= (r_rr_ptr[r_req_index] == WIDX'(WAYS - 1)) ?
                                 '0 : r_rr_ptr[r_req_index] + WIDX'(1);
      end
    end

    assign w_rr_cur = r_rr_ptr[w_index];
  end else begin : g_no_rr
    assign w_rr_cur = '0;
  end

  // Controller state and beat pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= STAT_NORMAL;
      r_counter <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
    end
  end

  // Next state, beat advance and RAM request generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_miss_start  = 1'b0;
    w_fill        = 1'b0;
    w_fill_done   = 1'b0;
    w_ram_en      = 1'b0;
    w_ram_write   = 1'b0;
    w_ram_addr    = '0;
    w_ram_wdata   = '0;
    case (r_state)
      STAT_NORMAL: begin
        if (bus.req && !w_hit) begin
          w_miss_start  = 1'b1;
          w_counter_nxt = '0;
          w_state_nxt   = w_victim_dirty ? STAT_WRITEBACK : STAT_REFILL;
        end
      end
      STAT_WRITEBACK: begin
        w_ram_en    = 1'b1;
        w_ram_write = 1'b1;
        w_ram_addr  = {r_wb_tag, r_req_index, r_counter};
        w_ram_wdata = w_way_rdata[r_way];
        if (bus.ram_ready) begin
          w_counter_nxt = r_counter + OFFSET_WIDTH'(1);
          if (r_counter == LAST_BEAT) begin
            w_state_nxt = STAT_REFILL;
          end
        end
      end
      STAT_REFILL: begin
        w_ram_en   = 1'b1;
        w_ram_addr = {r_req_tag, r_req_index, r_counter};
        if (bus.ram_ready) begin
          w_fill        = 1'b1;
          w_counter_nxt = r_counter + OFFSET_WIDTH'(1);
          if (r_counter == LAST_BEAT) begin
            w_fill_done = 1'b1;
            w_state_nxt = STAT_RESUME;
          end
        end
      end
      STAT_RESUME: begin
        w_state_nxt = STAT_NORMAL;
      end
      default: begin
        w_state_nxt = STAT_NORMAL;
      end
    endcase
  end

  // Miss bookkeeping: requested line and the victim (way and its old tag for writeback).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_tag   <= '0;
      r_req_index <= '0;
      r_way       <= '0;
      r_wb_tag    <= '0;
    end else if (w_miss_start) begin
      r_req_tag   <= w_tag;
      r_req_index <= w_index;
      r_way       <= w_victim;
      r_wb_tag    <= w_way_tag[w_victim];
    end
  end

  assign bus.ram_en    = w_ram_en;
  assign bus.ram_write = w_ram_write;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.rdata     = ((r_state == STAT_NORMAL) && w_hit) ? w_hit_word : '0;
  // Stall is forced low while reset is held even if the CPU keeps req asserted.
  assign bus.mem_stall = rst && (((r_state == STAT_NORMAL) && bus.req && !w_hit) ||
                                 (r_state != STAT_NORMAL));
  assign status  = r_state;
  assign counter = r_counter;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  // Free-running event counters that wrap at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if ((r_state == STAT_NORMAL) && bus.req && w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss_start)                                r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_miss_start && w_victim_dirty)              r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule
